norm_unit: RTL and testbench

- Iterative normalizer for the ALU_DIS lane. It is the inverse of the arithmetic shifter: given an operand, it finds the left-shift amount that normalizes it and returns both the amount and the normalized value.
- Serves CLZ/CLS-style vector ops and the pre-shift of divide/float-convert paths.
- Multi-cycle binary-search engine with a valid/ready handshake on both sides; one operand in flight.

---
 rtl/norm_unit_pkg.sv | 14 +
 rtl/norm_stage.sv | 32 +++
 rtl/norm_unit.sv | 121 ++++++++++++
 tb/tb_norm_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/norm_unit_pkg.sv
// Shared ALU definitions for the normalizer.
// FSM encoding and operand-format selectors.
package norm_unit_pkg;

  typedef enum logic [1:0] {
    NORM_IDLE,
    NORM_SEARCH,
    NORM_DONE
  } norm_state_t;

  localparam logic NORM_TC_UNSIGNED = 1'b0;
  localparam logic NORM_TC_SIGNED   = 1'b1;

endpackage

// File: rtl/norm_stage.sv
// One binary-search step of the normalizer.
// Tests the top 2^k bits (2^k+1 in signed mode) and offers the shifted word.
module norm_stage
  import norm_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LOG2W      = $clog2(DATA_WIDTH),
  parameter int KW         = (LOG2W > 1) ? $clog2(LOG2W) : 1
) (
  input  logic [DATA_WIDTH-1:0] work,
  input  logic [KW-1:0]         k,
  input  logic                  tc,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] shifted
);

  logic [DATA_WIDTH-1:0] probe;

  // Adjacent-bit XOR turns "top 2^k+1 bits equal" into "top 2^k bits zero".
  always_comb begin
    probe   = (tc == NORM_TC_SIGNED) ? (work ^ (work << 1)) : work;
    hit     = 1'b0;
    shifted = work;
    for (int j = 0; j < LOG2W; j++) begin
      if (k == KW'(j)) begin
        hit     = (probe >> (DATA_WIDTH - (1 << j))) == '0;
        shifted = work << (1 << j);
      end
    end
  end

endmodule

// File: rtl/norm_unit.sv
// Iterative CLZ/CLS normalizer: returns shift amount and normalized operand.
// Fixed-latency binary search, one stage per cycle, one operand in flight.
module norm_unit
  import norm_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         module_clk_i,
  input  logic                         module_rst_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic                         data_tc_i,
  input  logic [DATA_WIDTH-1:0]        a_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [DATA_WIDTH-1:0]        result_o,
  output logic [$clog2(DATA_WIDTH):0]  shamt_o,
  output logic                         zero_o
);

  localparam int LOG2W = $clog2(DATA_WIDTH);
  localparam int KW    = (LOG2W > 1) ? $clog2(LOG2W) : 1;
  localparam int SW    = LOG2W + 1;

  norm_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] work_q;
  logic [SW-1:0]         count_q;
  logic [KW-1:0]         k_q;
  logic                  tc_q;
  logic                  zero_q;

  logic [DATA_WIDTH-1:0] res_q;
  logic [SW-1:0]         shamt_q;
  logic                  zflag_q;

  logic                  hit;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] work_nx;
  logic [SW-1:0]         count_nx;

  norm_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOG2W      (LOG2W),
    .KW         (KW)
  ) u_stage (
    .work    (work_q),
    .k       (k_q),
    .tc      (tc_q),
    .hit     (hit),
    .shifted (shifted)
  );

  always_comb begin
    work_nx  = hit ? shifted : work_q;
    count_nx = hit ? (count_q + (SW'(1) << k_q)) : count_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORM_IDLE:   if (valid_i) state_d = NORM_SEARCH;
      NORM_SEARCH: if (k_q == '0) state_d = NORM_DONE;
      NORM_DONE:   if (ready_i) state_d = NORM_IDLE;
      default:     state_d = NORM_IDLE;
    endcase
  end

  always_ff @(posedge module_clk_i) begin
    if (module_rst_i) begin
      state_q <= NORM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge module_clk_i) begin
    if (module_rst_i) begin
      work_q  <= '0;
      count_q <= '0;
      k_q     <= '0;
      tc_q    <= NORM_TC_UNSIGNED;
      zero_q  <= 1'b0;
      res_q   <= '0;
      shamt_q <= '0;
      zflag_q <= 1'b0;
    end else begin
      unique case (state_q)
        NORM_IDLE: begin
          if (valid_i) begin
            work_q  <= a_i;
            tc_q    <= data_tc_i;
            count_q <= '0;
            k_q     <= KW'(LOG2W - 1);
            zero_q  <= (a_i == '0);
          end
        end
        NORM_SEARCH: begin
          work_q  <= work_nx;
          count_q <= count_nx;
          k_q     <= k_q - 1'b1;
          if (k_q == '0) begin
            res_q   <= work_nx;
            zflag_q <= zero_q;
            // The search tops out at W-1; a zero unsigned word means W.
            shamt_q <= (zero_q && tc_q == NORM_TC_UNSIGNED)
                       ? SW'(DATA_WIDTH) : count_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = (state_q == NORM_IDLE);
  assign valid_o  = (state_q == NORM_DONE);
  assign result_o = res_q;
  assign shamt_o  = shamt_q;
  assign zero_o   = zflag_q;

endmodule

// File: tb/tb_norm_unit.sv
// Directed and randomized checks for norm_unit.
// Expected values come from hand calculations and a bit-serial CLZ/CLS model.
module tb_norm_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic         ready_o;
  logic         data_tc_i;
  logic [W-1:0] a_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] result_o;
  logic [5:0]   shamt_o;
  logic         zero_o;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  norm_unit #(.DATA_WIDTH(W)) dut (
    .module_clk_i (clk),
    .module_rst_i (rst),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_tc_i    (data_tc_i),
    .a_i          (a_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .result_o     (result_o),
    .shamt_o      (shamt_o),
    .zero_o       (zero_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int ref_shamt(input logic [W-1:0] a, input logic tc);
    int n = 0;
    if (tc) begin
      for (int i = W - 2; i >= 0; i--) begin
        if (a[i] != a[W-1]) break;
        n++;
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (a[i]) break;
        n++;
      end
    end
    return n;
  endfunction

  task automatic wait_valid(output int n);
    n = 1;
    while (!valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a,
                        input logic tc, input logic [W-1:0] er,
                        input int es, input logic ez);
    int n;
    valid_i   = 1'b1;
    a_i       = a;
    data_tc_i = tc;
    @(posedge clk); #1;
    valid_i   = 1'b0;
    data_tc_i = ~tc;
    wait_valid(n);
    chk({tag, "_lat"}, n, 6);
    chk({tag, "_res"}, result_o, er);
    chk({tag, "_sh"}, shamt_o, es);
    chk({tag, "_z"}, zero_o, ez);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk({tag, "_drop"}, {ready_o, valid_o}, 2'b10);
  endtask

  initial begin
    int n;
    int t[3];
    logic ok;
    logic [W-1:0] hold;
    logic [W-1:0] ra;
    logic rtc;
    int rs;

    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    data_tc_i = 1'b0; a_i = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_out", {ready_o, valid_o, result_o, shamt_o, zero_o},
        {1'b1, 1'b0, 32'h0, 6'd0, 1'b0});

    run_op("u_one", 32'h0000_0001, 1'b0, 32'h8000_0000, 31, 1'b0);
    run_op("s_ff00", 32'hFFFF_FF00, 1'b1, 32'h8000_0000, 23, 1'b0);
    run_op("s_1234", 32'h0000_1234, 1'b1, 32'h48D0_0000, 18, 1'b0);
    run_op("u_zero", 32'h0, 1'b0, 32'h0, 32, 1'b1);
    run_op("s_zero", 32'h0, 1'b1, 32'h0, 31, 1'b1);
    run_op("s_ones", 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 31, 1'b0);
    run_op("u_norm", 32'h9ABC_DEF0, 1'b0, 32'h9ABC_DEF0, 0, 1'b0);
    run_op("s_norm", 32'hA000_0001, 1'b1, 32'hA000_0001, 0, 1'b0);
    run_op("s_pos1", 32'h0000_0001, 1'b1, 32'h4000_0000, 30, 1'b0);

    // Backpressure with a competing operand on the input
    valid_i = 1'b1; a_i = 32'h0000_0100; data_tc_i = 1'b0;
    @(posedge clk); #1;
    wait_valid(n);
    chk("bp_lat", n, 6);
    hold = result_o;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_i = (i % 2 == 0) ? 32'h0000_0003 : 32'hF000_0000;
      data_tc_i = i[0];
      @(posedge clk); #1;
      if (!valid_o || ready_o || result_o !== hold || shamt_o !== 6'd23)
        ok = 1'b0;
    end
    chk("bp_stable", ok, 1'b1);
    chk("bp_res", {result_o, shamt_o, zero_o}, {32'h8000_0000, 6'd23, 1'b0});
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("bp_idle", {ready_o, valid_o}, 2'b10);
    run_op("bp_next", 32'h0000_0003, 1'b0, 32'hC000_0000, 30, 1'b0);

    // Reset during the third SEARCH cycle
    valid_i = 1'b1; a_i = 32'h0000_00FF; data_tc_i = 1'b0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out", {ready_o, valid_o, result_o, shamt_o, zero_o},
        {1'b1, 1'b0, 32'h0, 6'd0, 1'b0});
    run_op("abort_next", 32'h4000_0000, 1'b0, 32'h8000_0000, 1, 1'b0);

    // Back-to-back with both handshakes held high
    ready_i = 1'b1; valid_i = 1'b1;
    a_i = 32'h00F0_0000; data_tc_i = 1'b0;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (!valid_o && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      t[r] = cyc;
      chk("b2b_sh", shamt_o, 6'd8);
      @(posedge clk); #1;
    end
    valid_i = 1'b0; ready_i = 1'b0;
    chk("b2b_per0", t[1] - t[0], 7);
    chk("b2b_per1", t[2] - t[1], 7);
    chk("b2b_idle", ready_o, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) ra = ~ra;
      if ($urandom_range(0, 49) == 0) ra = '0;
      rtc = 1'($urandom_range(0, 1));
      rs = ref_shamt(ra, rtc);
      run_op("rand", ra, rtc, ra << rs, rs, ra == '0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
